// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 transmitter driving open-drain clock/data pull-low enables
// Ports:
//   clock    - system clock (35.468 MHz)
//   power    - asynchronous active-low reset
//   start    - transfer request, accepted when busy=0
//   data     - byte to send, captured on acceptance
//   busy     - transfer in progress
//   done     - one-cycle pulse, byte acknowledged by device
//   error    - one-cycle pulse, timeout or missing ack
//   ps2CkI   - raw ps2 clock line level
//   ps2DqI   - raw ps2 data line level
//   ps2CkOe  - 1 pulls the clock line low
//   ps2DqOe  - 1 pulls the data line low
module ps2_host_tx #(
    parameter int CLK_HOLD = 4000,
    parameter int DQ_SETUP = 64,
    parameter int FILTER   = 8,
    parameter int TIMEOUT  = 709360
) (
    input  logic       clock,
    input  logic       power,
    input  logic       start,
    input  logic [7:0] data,
    output logic       busy,
    output logic       done,
    output logic       error,
    input  logic       ps2CkI,
    input  logic       ps2DqI,
    output logic       ps2CkOe,
    output logic       ps2DqOe
);
    localparam int HW = $clog2((CLK_HOLD > DQ_SETUP ? CLK_HOLD : DQ_SETUP) + 1);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int FW = $clog2(FILTER + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQUEST, SEND, ACK, FINISH} state_t;
    state_t        state_q, state_d;
    logic [1:0]    ck_sync_q, dq_sync_q;
    logic          ck_f_q, ck_f_d;
    logic [FW-1:0] flt_q, flt_d;
    logic [9:0]    shift_q, shift_d;
    logic [3:0]    bit_q, bit_d;
    logic [HW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] to_q, to_d;
    logic          dq_q, dq_d;
    logic          done_q, done_d;
    logic          error_q, error_d;
    logic          ck_s, dq_s, fall;
    assign ck_s = ck_sync_q[1];
    assign dq_s = dq_sync_q[1];
    // Filtered clock flips only on the FILTER-th consecutive differing sample.
    assign flt_d  = (ck_s == ck_f_q || flt_q == FW'(FILTER - 1)) ? '0 : flt_q + FW'(1);
    assign ck_f_d = (ck_s != ck_f_q && flt_q == FW'(FILTER - 1)) ? ck_s : ck_f_q;
    assign fall   = ck_f_q & ~ck_f_d;
    always_ff @(posedge clock or negedge power) begin
        if (!power) begin
            ck_sync_q <= 2'b11;
            dq_sync_q <= 2'b11;
            ck_f_q    <= 1'b1;
            flt_q     <= '0;
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            cnt_q     <= '0;
            to_q      <= '0;
            dq_q      <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            ck_sync_q <= {ck_sync_q[0], ps2CkI};
            dq_sync_q <= {dq_sync_q[0], ps2DqI};
            ck_f_q    <= ck_f_d;
            flt_q     <= flt_d;
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_q     <= bit_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
            dq_q      <= dq_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        dq_d    = dq_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    shift_d = {1'b1, ~^data, data};
                    cnt_d   = '0;
                    state_d = INHIBIT;
                end
            end
            INHIBIT: begin
                cnt_d = (cnt_q == HW'(CLK_HOLD - 1)) ? '0 : cnt_q + HW'(1);
                if (cnt_q == HW'(CLK_HOLD - 1)) state_d = REQUEST;
            end
            REQUEST: begin
                cnt_d = (cnt_q == HW'(DQ_SETUP - 1)) ? '0 : cnt_q + HW'(1);
                if (cnt_q == HW'(DQ_SETUP - 1)) begin
                    bit_d   = '0;
                    to_d    = '0;
                    dq_d    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                // Edge n drives bit n-1 of {stop, parity, data}; the stop bit releases the line.
                if (fall) begin
                    dq_d  = ~shift_q[bit_q];
                    bit_d = bit_q + 4'd1;
                    if (bit_q == 4'd9) state_d = ACK;
                end
            end
            ACK: begin
                if (fall) begin
                    error_d = dq_s;
                    state_d = dq_s ? IDLE : FINISH;
                end
            end
            FINISH: begin
                if (ck_f_q && dq_s) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // The timeout spans the whole device-clocked phase and overrides any other outcome.
        if (state_q inside {SEND, ACK, FINISH}) begin
            to_d = to_q + TW'(1);
            if (to_q == TW'(TIMEOUT - 1)) begin
                state_d = IDLE;
                dq_d    = 1'b0;
                done_d  = 1'b0;
                error_d = 1'b1;
            end
        end
    end
    assign busy    = state_q != IDLE;
    assign done    = done_q;
    assign error   = error_q;
    assign ps2CkOe = state_q inside {INHIBIT, REQUEST};
    assign ps2DqOe = state_q == REQUEST || (state_q == SEND && dq_q);
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with a PS/2 device model on the open-drain lines
module tb_ps2_host_tx;
    localparam int CLK_HOLD = 400;
    localparam int DQ_SETUP = 64;
    localparam int FILTER   = 8;
    localparam int TIMEOUT  = 4000;
    localparam int H        = 100;
    logic        clock = 1'b0;
    logic        power = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  data  = 8'h00;
    logic        busy, done, error, ps2CkOe, ps2DqOe;
    logic        ps2CkI, ps2DqI;
    logic        dev_ck = 1'b1;
    logic        dev_dq = 1'b1;
    int          checks = 0;
    int          failures = 0;
    int          done_n = 0, err_n = 0, both_n = 0, pulse_busy_n = 0;
    int          inh_n = 0, req_n = 0, restart_n = 0;
    logic        prev_done = 1'b0;
    assign ps2CkI = dev_ck & ~ps2CkOe;
    assign ps2DqI = dev_dq & ~ps2DqOe;
    always #14 clock = ~clock;
    ps2_host_tx #(
        .CLK_HOLD(CLK_HOLD),
        .DQ_SETUP(DQ_SETUP),
        .FILTER  (FILTER),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clock  (clock),
        .power  (power),
        .start  (start),
        .data   (data),
        .busy   (busy),
        .done   (done),
        .error  (error),
        .ps2CkI (ps2CkI),
        .ps2DqI (ps2DqI),
        .ps2CkOe(ps2CkOe),
        .ps2DqOe(ps2DqOe)
    );
    always @(negedge clock) begin
        if (done) done_n++;
        if (error) err_n++;
        if (done && error) both_n++;
        if ((done || error) && busy) pulse_busy_n++;
        if (ps2CkOe && !ps2DqOe) inh_n++;
        if (ps2CkOe && ps2DqOe) req_n++;
        if (prev_done && busy) restart_n++;
        prev_done = done;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic pulse_start(input logic [7:0] b);
        @(negedge clock);
        data  = b;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask
    task automatic wait_release();
        int n = 0;
        while (!(ps2CkOe && ps2DqOe) && n < 2000) begin
            @(negedge clock);
            n++;
        end
        check("reach_request", {31'b0, ps2CkOe & ps2DqOe}, 1);
        n = 0;
        while (ps2CkOe && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("clock_released", {31'b0, ps2CkOe}, 0);
    endtask
    // Device clocks 11 pulses, samples data before each rise, optionally acks in the 11th slot.
    task automatic dev_xfer(input logic ack, input int glitch_at, input int abort_at,
                            output logic [10:0] bits, output logic ack_seen);
        bits     = '0;
        ack_seen = 1'b1;
        repeat (50) @(negedge clock);
        bits[0] = ps2DqI;
        for (int i = 1; i <= 11; i++) begin
            dev_ck = 1'b0;
            if (i == abort_at) begin
                repeat (H / 2) @(negedge clock);
                return;
            end
            repeat (H) @(negedge clock);
            if (i <= 10) bits[i] = ps2DqI;
            else ack_seen = ps2DqI;
            dev_ck = 1'b1;
            if (i == 11) dev_dq = 1'b1;
            repeat (H / 2) @(negedge clock);
            if (i == glitch_at) begin
                dev_ck = 1'b0;
                repeat (3) @(negedge clock);
                dev_ck = 1'b1;
            end
            if (i == 10 && ack) dev_dq = 1'b0;
            repeat (H / 2) @(negedge clock);
        end
    endtask
    initial begin
        logic [10:0] bits;
        logic        ack_seen;
        int          d0, e0, i0, r0, s0, n;
        repeat (3) @(negedge clock);
        check("reset_busy", {31'b0, busy}, 0);
        check("reset_ckoe", {31'b0, ps2CkOe}, 0);
        check("reset_dqoe", {31'b0, ps2DqOe}, 0);
        check("reset_pulses", {30'b0, done, error}, 0);
        power = 1'b1;
        // 0xED with ack
        d0 = done_n; e0 = err_n; i0 = inh_n; r0 = req_n;
        pulse_start(8'hED);
        wait_release();
        check("ed_inhibit_cycles", inh_n - i0, CLK_HOLD);
        check("ed_request_cycles", req_n - r0, DQ_SETUP);
        dev_xfer(1'b1, 0, 0, bits, ack_seen);
        check("ed_bits", {21'b0, bits}, {21'b0, 11'b1_1_11101101_0});
        check("ed_ack", {31'b0, ack_seen}, 0);
        check("ed_done", done_n - d0, 1);
        check("ed_error", err_n - e0, 0);
        check("ed_busy", {31'b0, busy}, 0);
        // 0xF4: five ones, parity 0
        d0 = done_n;
        pulse_start(8'hF4);
        wait_release();
        dev_xfer(1'b1, 0, 0, bits, ack_seen);
        check("f4_bits", {21'b0, bits}, {21'b0, 11'b1_0_11110100_0});
        check("f4_done", done_n - d0, 1);
        // 0x00 without ack
        d0 = done_n; e0 = err_n;
        pulse_start(8'h00);
        wait_release();
        dev_xfer(1'b0, 0, 0, bits, ack_seen);
        check("nak_bits", {21'b0, bits}, {21'b0, 11'b1_1_00000000_0});
        check("nak_line", {31'b0, ack_seen}, 1);
        check("nak_error", err_n - e0, 1);
        check("nak_done", done_n - d0, 0);
        check("nak_lines", {30'b0, ps2CkOe, ps2DqOe}, 0);
        check("nak_busy", {31'b0, busy}, 0);
        // timeout: device silent after release
        d0 = done_n;
        pulse_start(8'h55);
        wait_release();
        n = 0;
        while (!error && n < TIMEOUT + 50) begin
            @(negedge clock);
            n++;
        end
        check("timeout_cycles", n, TIMEOUT);
        check("timeout_busy", {31'b0, busy}, 0);
        check("timeout_lines", {30'b0, ps2CkOe, ps2DqOe}, 0);
        check("timeout_done", done_n - d0, 0);
        // start held through 0xFF, data changed mid-transfer
        d0 = done_n; s0 = restart_n;
        @(negedge clock);
        data  = 8'hFF;
        start = 1'b1;
        wait_release();
        data = 8'h12;
        dev_xfer(1'b1, 0, 0, bits, ack_seen);
        check("held_bits", {21'b0, bits}, {21'b0, 11'b1_1_11111111_0});
        check("held_done", done_n - d0, 1);
        check("held_restart", restart_n - s0, 1);
        start = 1'b0;
        wait_release();
        dev_xfer(1'b1, 0, 0, bits, ack_seen);
        check("second_bits", {21'b0, bits}, {21'b0, 11'b1_1_00010010_0});
        check("second_done", done_n - d0, 2);
        // reset during bit 5 of 0xED (data bit 4 = 0, so data is pulled low)
        pulse_start(8'hED);
        wait_release();
        dev_xfer(1'b1, 0, 5, bits, ack_seen);
        check("abort_dq_before", {31'b0, ps2DqOe}, 1);
        d0 = done_n; e0 = err_n;
        #2 power = 1'b0;
        #1;
        check("abort_lines", {30'b0, ps2CkOe, ps2DqOe}, 0);
        check("abort_busy", {31'b0, busy}, 0);
        dev_ck = 1'b1;
        dev_dq = 1'b1;
        repeat (5) @(negedge clock);
        check("abort_pulses", (done_n - d0) + (err_n - e0), 0);
        power = 1'b1;
        d0 = done_n;
        pulse_start(8'hF4);
        wait_release();
        dev_xfer(1'b1, 0, 0, bits, ack_seen);
        check("after_reset_bits", {21'b0, bits}, {21'b0, 11'b1_0_11110100_0});
        check("after_reset_done", done_n - d0, 1);
        // 3-cycle clock glitch during SEND must not advance the bit index
        d0 = done_n;
        pulse_start(8'hA5);
        wait_release();
        dev_xfer(1'b1, 5, 0, bits, ack_seen);
        check("glitch_bits", {21'b0, bits}, {21'b0, 11'b1_1_10100101_0});
        check("glitch_done", done_n - d0, 1);
        check("never_both", both_n, 0);
        check("busy_low_on_pulse", pulse_busy_n, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter; the send direction of the keyboard link whose receive side already feeds the glue/keyboard matrix.
- Sends command bytes to the keyboard: 0xFF reset, 0xED plus mask for LEDs, 0xF4 enable.
- Drives the shared open-drain ps2 clock and data lines through active-high pull-low enables.
- Runs on the 35.468 MHz system clock, beside the existing PS/2 receiver.

Parameters:
- CLK_HOLD, 4000: cycles the host holds clock low to inhibit (about 113 us at 35.468 MHz; must be at least 100 us).
- DQ_SETUP, 64: cycles data is held low before clock is released.
- FILTER, 8: cycles the synchronised device clock must be stable before an edge is accepted.
- TIMEOUT, 709360: cycles allowed from clock release to ack (20 ms).

Ports:
- clock, input, 1: system clock, 35.468 MHz.
- power, input, 1: asynchronous active-low reset (0 = held in reset).
- start, input, 1: request strobe; accepted when start=1 and busy=0.
- data, input, 8: byte to send; captured on acceptance.
- busy, output, 1: transfer in progress.
- done, output, 1: one-cycle pulse, byte acknowledged by device.
- error, output, 1: one-cycle pulse, timeout or missing ack.
- ps2CkI, input, 1: raw ps2 clock line level.
- ps2DqI, input, 1: raw ps2 data line level.
- ps2CkOe, output, 1: 1 = pull clock line low.
- ps2DqOe, output, 1: 1 = pull data line low.

Behaviour:
- Reset (power=0, asynchronous): ps2CkOe=0, ps2DqOe=0, busy=0, done=0, error=0, state IDLE, all counters 0.
- Input conditioning:
  - ps2CkI and ps2DqI each pass through a 2-FF synchroniser.
  - Clock is filtered: its level changes only after FILTER consecutive equal samples.
  - Falling edge = filtered clock goes 1 to 0.
- Shift register: {stop=1, parity=~^data, data[7:0]}, captured at acceptance; parity is odd.
- IDLE: busy=0. On start: capture the byte, busy=1 from the next cycle, go to INHIBIT. start while busy=1 is ignored.
- INHIBIT: ps2CkOe=1, ps2DqOe=0 for CLK_HOLD cycles, then REQUEST.
- REQUEST: ps2CkOe=1, ps2DqOe=1 (start bit) for DQ_SETUP cycles. Then ps2CkOe=0, clear bit counter and timeout counter, go to SEND.
- SEND: bits change only at filtered falling edges while clock is low.
  - Edges 1 to 8: ps2DqOe = ~data[n-1], LSB first.
  - Edge 9: ps2DqOe = ~parity.
  - Edge 10: ps2DqOe=0 (stop bit, line released). Go to ACK.
- ACK:
  - At the next falling edge (the 11th), sample synchronised data.
  - Data 0: go to FINISH.
  - Data 1: pulse error, go to IDLE.
- FINISH: wait until both filtered clock and synchronised data are 1, then pulse done for 1 cycle, busy=0, go to IDLE.
- Timeout:
  - The counter runs through SEND, ACK and FINISH and is never reset by edges.
  - On reaching TIMEOUT: release both lines, pulse error, go to IDLE.
- done and error are never both 1 in the same cycle. busy falls in the same cycle as the done or error pulse.
- Reset mid-transfer: both lines released immediately, no done or error pulse.
- Line ownership:
  - ps2CkOe=1 only in INHIBIT and REQUEST.
  - ps2DqOe may be 1 only in REQUEST and SEND.
  - The receiver ignores the line while busy=1.

Test Plan:
- Byte 0xED with a device model clocking at 12.5 kHz that acks ->
  - clock is low for 4000 cycles, data is low from cycle 4000 to 4064, then clock is released;
  - bits on data, sampled at device rising edges: 0(start),1,0,1,1,0,1,1,1, parity 1, stop 1;
  - ack=0, then a done pulse, busy=0, no error.
- Byte 0xF4 (five ones) -> parity bit 0 on the line; done pulses.
- Byte 0x00 -> parity 1; device leaves data high in the ack slot -> error pulse on that edge, no done, both lines released.
- Device never clocks after release -> error pulse exactly TIMEOUT cycles after ps2CkOe falls, busy=0.
- start held high through a transfer of 0xFF with data changed to 0x12 mid-transfer ->
  - the line carries 0xFF;
  - a second transfer begins the cycle after done, since start is still 1 in IDLE.
- power driven low during SEND bit 5 -> ps2CkOe=ps2DqOe=busy=0 asynchronously, no done or error pulse; after release, a new start works normally.
- 3-cycle glitches on ps2CkI during SEND (below FILTER) -> the bit index does not advance.
